// File: rtl/stopwatch_ctl.sv
// Stopwatch control: two debounced push-buttons (start/pause, clear) driving
// an IDLE/RUN/PAUSE state machine with registered control outputs.
module stopwatch_ctl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
    output logic count_enabled,
    output logic init_regs,
    output logic run_led,
    output logic pause_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button index 0 = start/stop, 1 = clear.
    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         deb_prev_q;
    logic [1:0]         press_q, press_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    state_t state_q, state_d;
    logic   count_enabled_q, count_enabled_d;
    logic   init_regs_q, init_regs_d;
    logic   run_led_q, run_led_d;
    logic   pause_led_q, pause_led_d;

    assign raw = {btn_clear, btn_start_stop};

    // Debounce: count consecutive disagreeing cycles, flip the level once the
    // disagreement has lasted DEBOUNCE_CYCLES; any agreement restarts the count.
    // The press pulse is taken from the registered level so it lands one cycle
    // after the level itself changes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d = deb_q & ~deb_prev_q;
    end

    // Synchronizers, debounce state and press pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= press_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state and next outputs; clear beats start/stop in the same cycle.
    always_comb begin
        state_d = state_q;
        if (press_q[BTN_CLR]) begin
            state_d = IDLE;
        end else if (press_q[BTN_SS]) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
        init_regs_d     = press_q[BTN_CLR];
        count_enabled_d = (state_d == RUN);
        run_led_d       = (state_d == RUN);
        pause_led_d     = (state_d == PAUSE);
    end

    // State register with registered outputs; reset forces an init pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            count_enabled_q <= 1'b0;
            init_regs_q     <= 1'b1;
            run_led_q       <= 1'b0;
            pause_led_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_enabled_q <= count_enabled_d;
            init_regs_q     <= init_regs_d;
            run_led_q       <= run_led_d;
            pause_led_q     <= pause_led_d;
        end
    end

    assign count_enabled = count_enabled_q;
    assign init_regs     = init_regs_q;
    assign run_led       = run_led_q;
    assign pause_led     = pause_led_q;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Bench for stopwatch_ctl with DEBOUNCE_CYCLES=4. Each test schedules per-cycle
// inputs with the expected outputs after that edge, then drains the queue.
module tb_stopwatch_ctl;

    localparam int unsigned D   = 4;
    localparam int          LAT = D + 4;

    // Expected output vector order: {count_enabled, init_regs, run_led, pause_led}
    localparam logic [3:0] E_IDLE  = 4'b0000;
    localparam logic [3:0] E_INIT  = 4'b0100;
    localparam logic [3:0] E_RUN   = 4'b1010;
    localparam logic [3:0] E_PAUSE = 4'b0001;

    typedef struct {
        logic       rst;
        logic       ss;
        logic       clr;
        logic [3:0] exp;
        string      nm;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_start_stop = 1'b0;
    logic btn_clear = 1'b0;
    logic count_enabled, init_regs, run_led, pause_led;

    int   checks = 0;
    int   failures = 0;
    ent_t q[$];

    stopwatch_ctl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .count_enabled  (count_enabled),
        .init_regs      (init_regs),
        .run_led        (run_led),
        .pause_led      (pause_led)
    );

    always #5 clk = ~clk;

    task automatic sched(input logic rst, input logic ss, input logic clr,
                         input logic [3:0] exp, input int n, input string nm);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e.rst = rst; e.ss = ss; e.clr = clr; e.exp = exp; e.nm = nm;
            q.push_back(e);
        end
    endtask

    // Raw press held for 'hold' edges; outputs change on edge LAT.
    task automatic sched_press(input logic ss, input logic clr, input int hold, input int total,
                               input logic [3:0] b, input logic [3:0] a8, input logic [3:0] aft,
                               input string nm);
        ent_t e;
        for (int k = 1; k <= total; k++) begin
            e.rst = 1'b0;
            e.ss  = (k <= hold) ? ss : 1'b0;
            e.clr = (k <= hold) ? clr : 1'b0;
            e.exp = (k < LAT) ? b : ((k == LAT) ? a8 : aft);
            e.nm  = nm;
            q.push_back(e);
        end
    endtask

    task automatic sched_reset();
        sched(1'b1, 1'b0, 1'b0, E_INIT, 2, "rst");
        sched(1'b0, 1'b0, 1'b0, E_IDLE, 3, "rst_rel");
    endtask

    task automatic test_reset();
        ent_t e;
        int   cyc = 0;
        sched(1'b1, 1'b0, 1'b0, E_INIT, 3, "reset_hold");
        sched(1'b0, 1'b0, 1'b0, E_IDLE, 6, "reset_idle");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
            // One cycle after the last reset edge, init_regs must still be high.
            if (e.rst && q.size() > 0 && !q[0].rst) begin
                reset = 1'b0;
                checks++;
                if (init_regs !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_init_after got=%b exp=1", init_regs);
                end
            end
        end
    endtask

    task automatic test_bounce();
        ent_t       e;
        int         cyc = 0;
        logic [5:0] pat;
        pat = 6'b101101;
        sched_reset();
        for (int k = 5; k >= 0; k--) sched(1'b0, pat[k], 1'b0, E_IDLE, 1, "bounce");
        sched(1'b0, 1'b0, 1'b0, E_IDLE, 15, "bounce_after");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
        end
    endtask

    task automatic test_start_hold();
        ent_t e;
        int   cyc = 0;
        int   rises = 0;
        logic prev_ce = 1'b0;
        sched_reset();
        sched_press(1'b1, 1'b0, 20, 30, E_IDLE, E_RUN, E_RUN, "start_hold");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            if (count_enabled === 1'b1 && prev_ce === 1'b0) rises++;
            prev_ce = count_enabled;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL start_hold_rises got=%0d exp=1", rises);
        end
    endtask

    task automatic test_sequence();
        ent_t e;
        int   cyc = 0;
        sched_reset();
        sched_press(1'b1, 1'b0, 10, 20, E_IDLE, E_RUN, E_RUN, "seq_start");
        sched_press(1'b1, 1'b0, 10, 20, E_RUN, E_PAUSE, E_PAUSE, "seq_pause");
        sched_press(1'b0, 1'b1, 10, 20, E_PAUSE, E_INIT, E_IDLE, "seq_clear");
        sched_press(1'b1, 1'b0, 10, 20, E_IDLE, E_RUN, E_RUN, "seq_restart");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
        end
    endtask

    task automatic test_both_pressed();
        ent_t e;
        int   cyc = 0;
        sched_reset();
        sched_press(1'b1, 1'b0, 10, 20, E_IDLE, E_RUN, E_RUN, "both_setup");
        sched_press(1'b1, 1'b1, 10, 20, E_RUN, E_INIT, E_IDLE, "both_press");
        sched(1'b0, 1'b0, 1'b0, E_IDLE, 20, "both_after");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
        end
    endtask

    task automatic test_reset_in_run();
        ent_t e;
        int   cyc = 0;
        sched_reset();
        // Press and keep holding start/stop into and through the reset.
        sched_press(1'b1, 1'b0, 12, 12, E_IDLE, E_RUN, E_RUN, "rir_start");
        sched(1'b1, 1'b1, 1'b0, E_INIT, 1, "rir_reset");
        sched(1'b0, 1'b1, 1'b0, E_IDLE, LAT - 1, "rir_wait");
        sched(1'b0, 1'b1, 1'b0, E_RUN, 20, "rir_run");
        while (q.size() > 0) begin
            e = q.pop_front();
            reset = e.rst; btn_start_stop = e.ss; btn_clear = e.clr;
            @(posedge clk); #1; cyc++;
            checks++;
            if ({count_enabled, init_regs, run_led, pause_led} !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", e.nm, cyc,
                         {count_enabled, init_regs, run_led, pause_led}, e.exp);
            end
        end
        btn_start_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_start_hold();
        test_sequence();
        test_both_pressed();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctl.md
STOPWATCH_CTL -- requirements
Module: stopwatch_ctl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz): consecutive stable cycles required to accept a button change; legal range 1 .. 2^24-1.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn_start_stop  input  1  raw, asynchronous, bouncy push-button; start/pause toggle.
REQ-005 SHALL have port btn_clear  input  1  raw, asynchronous, bouncy push-button; stop and zero.
REQ-006 SHALL have port count_enabled  output  1  registered; high while the downstream counter is to advance.
REQ-007 SHALL have port init_regs  output  1  registered; one-cycle pulse that zeroes the downstream counter.
REQ-008 SHALL have port run_led  output  1  registered; high in state RUN.
REQ-009 SHALL have port pause_led  output  1  registered; high in state PAUSE.

Function
REQ-010 SHALL pass each button through its own 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized button with its own counter, sized $clog2(DEBOUNCE_CYCLES+1) bits.
REQ-012 Counter SHALL clear on every cycle where the synchronized value equals the debounced level.
REQ-013 Counter SHALL increment on every cycle where the synchronized value differs from the debounced level.
REQ-014 Debounced level SHALL toggle, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ; the counter never wraps.
REQ-015 SHALL generate a one-cycle press pulse, registered, on each 0->1 transition of a debounced level; 1->0 transitions generate nothing.
REQ-016 SHALL implement FSM states IDLE (cleared, stopped), RUN and PAUSE.
REQ-017 Transitions on start_stop pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-018 Transitions on clear pulse: RUN->IDLE, PAUSE->IDLE, IDLE->IDLE; every clear pulse SHALL also assert init_regs for exactly the next cycle.
REQ-019 If both pulses occur in the same cycle, clear SHALL win; start_stop is discarded, not deferred.
REQ-020 count_enabled SHALL be 1 exactly while the registered state is RUN.
REQ-021 count_enabled and init_regs SHALL never both be 1 in the same cycle.
REQ-022 Latency: a clean raw 0->1 press (held long enough) SHALL change the FSM outputs on the (DEBOUNCE_CYCLES+4)th rising edge after the first edge that samples the raw input high.
REQ-023 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no pulse and no state change.
REQ-024 Holding a button indefinitely SHALL produce exactly one pulse.
REQ-025 SHALL be synthesizable for XC7A35T with no latches, no gated clocks and no combinational outputs.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL load: state IDLE, count_enabled=0, init_regs=1, run_led=0, pause_led=0, debounced levels=0, debounce counters=0, synchronizers=0, press pulses=0.
REQ-027 On the first edge with reset=0, init_regs SHALL return to 0 unless a clear pulse is present.
REQ-028 Reset SHALL take precedence over all pulses, including a reset asserted mid-debounce or while in RUN; no press SHALL be recognised from a button already held through reset until the debounced level has first seen it as pressed, i.e. a button held across reset produces one pulse after DEBOUNCE_CYCLES+3 cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset then idle -> init_regs=1 during reset and one cycle after; count_enabled=0, run_led=0, pause_led=0.
REQ-030 start_stop held 20 cycles -> count_enabled rises on edge 8 after first high sample; exactly one rise; run_led=1.
REQ-031 start_stop bouncing 1,0,1,1,0,1 (runs <4) then low -> no state change, count_enabled stays 0.
REQ-032 Sequence: press start, press start, press clear -> states RUN, PAUSE, IDLE; count_enabled 1 then 0; one-cycle init_regs pulse on the clear; pause_led=1 only in PAUSE.
REQ-033 Both buttons pressed on the same cycle from RUN -> state IDLE, init_regs pulse, count_enabled=0, no later RUN.
REQ-034 reset asserted for 1 cycle while in RUN with start_stop held -> IDLE, init_regs=1; one start_stop pulse 7 cycles after reset release; state RUN.
